// File: rtl/int_sched_ctrl.sv
// int_sched_ctrl: interrupt scheduler with an interval timer and edge-detected external sources.
// Priority arbitration; the CPU handshake uses int_req, int_ack and int_eoi.
//   clk, rst        : board clock; asynchronous active-high reset
//   src_in          : raw external interrupt lines; bit k is source k+1
//   per_we/per_wdata: load the timer period and restart the down-counter
//   mask_we/wdata   : enable mask; a 1 lets a source take part in arbitration
//   int_ack, int_eoi: CPU accepts the request / signals end of interrupt
//   int_req, int_id : request to the CPU and the requested or in-service source
//   pending         : latched events
//   in_service      : sources being serviced
//   tmr_tick        : one-cycle pulse on timer expiry
// Build option INT_NEST_EN: a higher-priority source may preempt one in service,
// and in_service becomes a multi-hot stack.
module int_sched_ctrl #(
   parameter int N_SRC = 4,
   parameter int TMR_W = 32,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-2:0] src_in,
   input  logic             per_we,
   input  logic [TMR_W-1:0] per_wdata,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             int_ack,
   input  logic             int_eoi,
   output logic             int_req,
   output logic [ID_W-1:0]  int_id,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] in_service,
   output logic             tmr_tick
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2;
   logic [1:0]       state;
   logic [N_SRC-2:0] sync1, sync2, sync3;
   logic [TMR_W-1:0] period, cnt;
   logic [N_SRC-1:0] mask, eligible, set_vec, clr_vec, id_oh;
   logic [ID_W-1:0]  winner;
   logic             tmr_exp;
`ifdef INT_NEST_EN
   logic [N_SRC-1:0] isv_next;
`endif

   function automatic logic [ID_W-1:0] lo_idx(input logic [N_SRC-1:0] v);
      lo_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (v[i]) lo_idx = ID_W'(i);
   endfunction

   // A period write restarts the timer, so it suppresses an expiry in the same cycle.
   assign tmr_exp  = !per_we && period != '0 && cnt == TMR_W'(1);
   assign set_vec  = {sync2 & ~sync3, tmr_exp};
   assign eligible = pending & mask;
   assign winner   = lo_idx(eligible);
   assign id_oh    = N_SRC'(1) << int_id;
   assign clr_vec  = (state == REQ && int_ack) ? id_oh : '0;
`ifdef INT_NEST_EN
   assign isv_next = in_service & ~(N_SRC'(1) << lo_idx(in_service));
`endif

   // sync3 holds the previous synchronized value for rising-edge detection.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= src_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         period   <= '0;
         cnt      <= '0;
         tmr_tick <= 1'b0;
      end else if (per_we) begin
         period   <= per_wdata;
         cnt      <= per_wdata;
         tmr_tick <= 1'b0;
      end else begin
         tmr_tick <= tmr_exp;
         if (tmr_exp) cnt <= period;
         else if (period != '0) cnt <= cnt - TMR_W'(1);
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) mask <= '0;
      else if (mask_we) mask <= mask_wdata;

   // A new event on the bit being acknowledged wins over the clear and is not lost.
   always_ff @(posedge clk or posedge rst)
      if (rst) pending <= '0;
      else pending <= (pending & ~clr_vec) | set_vec;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         int_req    <= 1'b0;
         int_id     <= '0;
         in_service <= '0;
      end else begin
         case (state)
            IDLE:
               if (|eligible) begin
                  int_id  <= winner;
                  int_req <= 1'b1;
                  state   <= REQ;
               end
            REQ:
               if (int_ack) begin
                  int_req    <= 1'b0;
                  in_service <= in_service | id_oh;
                  state      <= SVC;
               end
            SVC:
`ifdef INT_NEST_EN
               if (int_eoi) begin
                  in_service <= isv_next;
                  int_id     <= lo_idx(isv_next);
                  state      <= (isv_next == '0) ? IDLE : SVC;
               end else if (|eligible && winner < lo_idx(in_service)) begin
                  int_id  <= winner;
                  int_req <= 1'b1;
                  state   <= REQ;
               end
`else
               if (int_eoi) begin
                  in_service <= '0;
                  state      <= IDLE;
               end
`endif
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_int_sched_ctrl.sv
// tb_int_sched_ctrl: directed self-checking bench for int_sched_ctrl.
module tb_int_sched_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic [2:0]  src_in = '0;
   logic        per_we = 1'b0, mask_we = 1'b0, int_ack = 1'b0, int_eoi = 1'b0;
   logic [31:0] per_wdata = '0;
   logic [3:0]  mask_wdata = '0;
   logic        int_req, tmr_tick;
   logic [1:0]  int_id;
   logic [3:0]  pending, in_service;
   int          n_tests = 0, n_fail = 0;

   int_sched_ctrl dut (
      .clk(clk), .rst(rst), .src_in(src_in), .per_we(per_we), .per_wdata(per_wdata),
      .mask_we(mask_we), .mask_wdata(mask_wdata), .int_ack(int_ack), .int_eoi(int_eoi),
      .int_req(int_req), .int_id(int_id), .pending(pending), .in_service(in_service),
      .tmr_tick(tmr_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      while (!int_req && k < 50) begin
         tick(1);
         k++;
      end
      chk(tag, {31'd0, int_req}, 1);
   endtask

   task automatic serve(input string tag, input int id);
      wait_req({tag, "_req"});
      chk({tag, "_id"}, {30'd0, int_id}, id);
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
      chk({tag, "_isv"}, {28'd0, in_service}, 32'd1 << id);
      chk({tag, "_reqlo"}, {31'd0, int_req}, 0);
      int_eoi = 1'b1;
      tick(1);
      int_eoi = 1'b0;
      chk({tag, "_eoi"}, {28'd0, in_service}, 0);
   endtask

   initial begin
      tick(2);
      chk("rst_req", {31'd0, int_req}, 0);
      chk("rst_id", {30'd0, int_id}, 0);
      chk("rst_pend", {28'd0, pending}, 0);
      chk("rst_isv", {28'd0, in_service}, 0);
      chk("rst_tick", {31'd0, tmr_tick}, 0);
      rst = 1'b0;
      // timer with period 10
      mask_we = 1'b1; mask_wdata = 4'b1111; per_we = 1'b1; per_wdata = 10;
      tick(1);
      mask_we = 1'b0; per_we = 1'b0;
      tick(9);
      chk("tmr_early", {31'd0, tmr_tick}, 0);
      tick(1);
      chk("tmr_tick1", {31'd0, tmr_tick}, 1);
      chk("tmr_pend", {28'd0, pending}, 4'b0001);
      chk("tmr_noreq", {31'd0, int_req}, 0);
      tick(1);
      chk("tmr_req", {31'd0, int_req}, 1);
      chk("tmr_id", {30'd0, int_id}, 0);
      chk("tmr_pulse", {31'd0, tmr_tick}, 0);
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
      chk("tmr_ack_pend", {28'd0, pending}, 0);
      chk("tmr_ack_isv", {28'd0, in_service}, 4'b0001);
      int_eoi = 1'b1;
      tick(1);
      int_eoi = 1'b0;
      chk("tmr_eoi_isv", {28'd0, in_service}, 0);
      tick(7);
      chk("tmr_tick2", {31'd0, tmr_tick}, 1);
      per_we = 1'b1; per_wdata = 0;
      tick(1);
      per_we = 1'b0;
      serve("tmr2", 0);
      chk("tmr_off_pend", {28'd0, pending}, 0);
      // strobes outside their states are ignored
      int_ack = 1'b1; int_eoi = 1'b1;
      tick(1);
      int_ack = 1'b0; int_eoi = 1'b0;
      tick(1);
      chk("ign_req", {31'd0, int_req}, 0);
      chk("ign_isv", {28'd0, in_service}, 0);
      // two external sources together
      src_in = 3'b110;
      tick(2);
      chk("ext_lat2", {28'd0, pending}, 0);
      tick(1);
      chk("ext_lat3", {28'd0, pending}, 4'b1100);
      serve("ext2", 2);
      chk("ext_left", {28'd0, pending}, 4'b1000);
      serve("ext3", 3);
      chk("ext_level", {28'd0, pending}, 0);
      src_in = 3'b000;
      tick(4);
      // mask gates arbitration only
      mask_we = 1'b1; mask_wdata = 4'b0111;
      tick(1);
      mask_we = 1'b0;
      src_in = 3'b100;
      tick(3);
      chk("msk_pend", {28'd0, pending}, 4'b1000);
      tick(3);
      chk("msk_noreq", {31'd0, int_req}, 0);
      mask_we = 1'b1; mask_wdata = 4'b1111;
      tick(1);
      mask_we = 1'b0;
      chk("msk_req0", {31'd0, int_req}, 0);
      tick(1);
      chk("msk_req1", {31'd0, int_req}, 1);
      chk("msk_id", {30'd0, int_id}, 3);
      serve("msk", 3);
      src_in = 3'b000;
      tick(4);
      // new edge lands in the ack cycle: set wins over clear
      src_in = 3'b010;
      tick(3);
      chk("col_pend", {28'd0, pending}, 4'b0100);
      tick(1);
      chk("col_req", {31'd0, int_req}, 1);
      chk("col_id", {30'd0, int_id}, 2);
      src_in = 3'b000;
      tick(2);
      src_in = 3'b010;
      tick(2);
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
      chk("col_keep", {28'd0, pending}, 4'b0100);
      chk("col_isv", {28'd0, in_service}, 4'b0100);
      chk("col_reqlo", {31'd0, int_req}, 0);
      int_eoi = 1'b1;
      tick(1);
      int_eoi = 1'b0;
      chk("col_eoi", {28'd0, in_service}, 0);
      serve("col2", 2);
      src_in = 3'b000;
      tick(4);
      // reset while in service
      mask_we = 1'b1; mask_wdata = 4'b1000; per_we = 1'b1; per_wdata = 3;
      src_in = 3'b110;
      tick(1);
      mask_we = 1'b0; per_we = 1'b0;
      wait_req("rs_req");
      chk("rs_id", {30'd0, int_id}, 3);
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
      chk("rs_isv", {28'd0, in_service}, 4'b1000);
      tick(3);
      chk("rs_pend", {28'd0, pending}, 4'b0101);
      src_in = 3'b000;
      rst = 1'b1;
      #1;
      chk("rs_a_req", {31'd0, int_req}, 0);
      chk("rs_a_id", {30'd0, int_id}, 0);
      chk("rs_a_pend", {28'd0, pending}, 0);
      chk("rs_a_isv", {28'd0, in_service}, 0);
      chk("rs_a_tick", {31'd0, tmr_tick}, 0);
      tick(2);
      rst = 1'b0;
      tick(10);
      chk("rs_quiet_pend", {28'd0, pending}, 0);
      mask_we = 1'b1; mask_wdata = 4'b1111;
      tick(1);
      mask_we = 1'b0;
      tick(5);
      chk("rs_quiet_req", {31'd0, int_req}, 0);
`ifdef INT_NEST_EN
      // timer preempts source 3
      src_in = 3'b100;
      wait_req("nst_req3");
      chk("nst_id3", {30'd0, int_id}, 3);
      int_ack = 1'b1;
      tick(1);
      int_ack = 1'b0;
      src_in = 3'b000;
      per_we = 1'b1; per_wdata = 5;
      tick(1);
      per_we = 1'b0;
      wait_req("nst_req0");
      chk("nst_id0", {30'd0, int_id}, 0);
      int_ack = 1'b1; per_we = 1'b1; per_wdata = 0;
      tick(1);
      int_ack = 1'b0; per_we = 1'b0;
      chk("nst_isv2", {28'd0, in_service}, 4'b1001);
      int_eoi = 1'b1;
      tick(1);
      int_eoi = 1'b0;
      chk("nst_isv1", {28'd0, in_service}, 4'b1000);
      chk("nst_id_back", {30'd0, int_id}, 3);
      int_eoi = 1'b1;
      tick(1);
      int_eoi = 1'b0;
      chk("nst_isv0", {28'd0, in_service}, 0);
      tick(2);
      chk("nst_idle", {31'd0, int_req}, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/int_sched_ctrl.md
Name: int_sched_ctrl

Overview:
- Interrupt scheduler for the single-cycle CPU's interrupt application. Replaces the tied-off interrupt line.
- Runs a programmable interval timer as source 0 and edge-detects external sources 1..N_SRC-1.
- Latches events as pending, masks them, picks the highest-priority one, and raises it to the CPU using a req/ack/eoi handshake.
- Sits beside the clock divider. All logic runs on the fast board clock clk.

Parameters:
- N_SRC, 4, number of interrupt sources (2..8); source 0 is the timer, lowest index is highest priority.
- TMR_W, 32, width of the timer period register and down-counter.
- ID_W, 2, width of int_id; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- src_in  in  N_SRC-1  raw external interrupt inputs, asynchronous to clk; bit k maps to source k+1
- per_we  in  1  write strobe for the timer period
- per_wdata  in  TMR_W  timer period value
- mask_we  in  1  write strobe for the enable mask
- mask_wdata  in  N_SRC  mask value; 1 = source enabled
- int_ack  in  1  CPU accepts the current request
- int_eoi  in  1  CPU end-of-interrupt strobe
- int_req  out  1  interrupt request to the CPU
- int_id  out  ID_W  ID of the requested or in-service source
- pending  out  N_SRC  pending register
- in_service  out  N_SRC  one-hot in-service register
- tmr_tick  out  1  one-cycle pulse when the timer expires

Behaviour:
- Reset values: int_req=0, int_id=0, pending=0, in_service=0, tmr_tick=0. Internally: mask=0, period=0, counter=0, FSM=IDLE. Reset mid-handshake aborts it with no residual state.
- External sources:
  - Each src_in bit passes through a 2-flop synchronizer.
  - A rising edge on the synchronized value sets pending[k+1] one cycle after the second flop.
  - Total latency from an input change to pending set is 3 clk.
  - A level held high produces exactly one event.
- Timer:
  - per_we loads period <= per_wdata and counter <= per_wdata in the same cycle.
  - If period=0 the timer is stopped: no ticks, counter holds 0.
  - Otherwise the counter decrements every clk. When the counter equals 1, next cycle it reloads to period, tmr_tick pulses, and pending[0] is set. The tick period is therefore exactly `period` cycles.
- Mask: mask_we writes mask. Pending bits are set regardless of the mask; the mask gates only arbitration.
- Arbitration: eligible = pending & mask. The winner is the lowest set index.
- FSM:
  - IDLE: if eligible != 0, then next cycle int_id <= winner, int_req <= 1, go to REQ. Otherwise stay.
  - REQ: int_req held high and int_id held stable. A later mask or pending change does not withdraw or alter the request. When int_ack=1: next cycle int_req <= 0, pending[int_id] cleared, in_service[int_id] set, go to SVC.
  - SVC: int_id holds the serviced ID. On int_eoi=1: next cycle in_service cleared, go to IDLE. A new request can be raised at the earliest 1 cycle after returning to IDLE.
- Ignored strobes:
  - int_ack outside REQ is ignored.
  - int_eoi outside SVC is ignored.
  - int_ack and int_eoi together in REQ: only ack acts.
- Set/clear collision: if a set event and the ack clear hit the same pending bit in one cycle, the set wins. The bit stays 1, so the new event is not lost.
- A repeated event while a bit is already pending is merged; there is no counting.

Optional Feature:
- Macro: INT_NEST_EN.
- With INT_NEST_EN defined:
  - In SVC, if the eligible winner has a strictly higher priority (lower index) than every set in_service bit, the FSM enters REQ for it. in_service becomes a multi-hot stack.
  - On ack the new bit is added to in_service.
  - int_eoi clears the highest-priority (lowest index) set in_service bit.
  - The FSM returns to IDLE only when in_service becomes 0. Otherwise it stays in SVC and int_id shows the highest-priority remaining in-service ID.
- Without the macro: strictly non-nested operation as specified above; in_service is always one-hot or zero.

Test Plan:
- Reset, mask=4'b1111, per_wdata=10 → tmr_tick pulses every 10 cycles. First int_req 1 cycle after pending[0] sets, with int_id=0. Ack → pending[0]=0, in_service=4'b0001. Eoi → in_service=0.
- src_in=3'b110 raised in the same cycle, mask=4'b1111, period=0 → pending=4'b1100 after 3 clk. Request id=2 first; after ack+eoi, request id=3.
- mask=4'b0111, src_in[2] rises → pending[3]=1, no int_req. Write mask=4'b1111 → int_req 1 cycle later with id=3.
- In REQ with id=2, src_in[1] re-asserts so its rising edge lands in the ack cycle → pending[2] stays 1 after ack. A second request for id=2 follows eoi.
- Assert rst while in SVC with pending=4'b0101 → all outputs 0 immediately. No request after release until new events arrive.
- INT_NEST_EN: in SVC id=3, the timer expires → int_req with id=0. Ack → in_service=4'b1001. Eoi → 4'b1000, int_id=3. Eoi → IDLE.
